// File: rtl/wb_i2c_reg_slave.sv
// Wishbone register front-end for the I2C master: CSR/DPR/CMDR/FSMR, wait-state ack, command handshake.
// Optional macro WB_I2C_REG_SLAVE_IRQ_EN enables the CSR.IE bit and the irq_o completion interrupt.
module wb_i2c_reg_slave #(
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  irq_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [2:0]            cmd_o,
  output logic [7:0]            cmd_data_o,
  input  logic                  done_i,
  input  logic [2:0]            done_sts_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  bus_busy_i,
  input  logic [7:0]            fsm_state_i
);

`ifdef WB_I2C_REG_SLAVE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [1:0] A_CSR  = 2'd0;
  localparam logic [1:0] A_DPR  = 2'd1;
  localparam logic [1:0] A_CMDR = 2'd2;
  localparam logic [1:0] A_FSMR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } bus_state_t;

  bus_state_t state;
  logic [3:0] wait_cnt;
  logic       req;
  logic [1:0] reg_adr;
  logic       wr_ack;
  logic       rd_ack;

  logic       e_bit;
  logic       ie_bit;
  logic       busy;
  logic       don;
  logic       nak;
  logic       al;
  logic       err;
  logic       irq_q;
  logic [7:0] rx_data;
  logic [7:0] rdata;

  assign req     = cyc_i & stb_i;
  assign reg_adr = adr_i[1:0];
  assign wr_ack  = ack_o & we_i;
  assign rd_ack  = ack_o & ~we_i;
  assign irq_o   = IRQ_EN & irq_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ack_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ack_o    <= 1'b0;
          wait_cnt <= '0;
          if (req) begin
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
            end else begin
              state <= S_ACK;
              ack_o <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'(WAIT_STATES - 1)) begin
            state <= S_ACK;
            ack_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_ACK: begin
          ack_o <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ack_o <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // done_i is applied last so it overrides a same-cycle CMDR read clearing irq
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_bit       <= 1'b0;
      ie_bit      <= 1'b0;
      busy        <= 1'b0;
      don         <= 1'b1;
      nak         <= 1'b0;
      al          <= 1'b0;
      err         <= 1'b0;
      irq_q       <= 1'b0;
      rx_data     <= '0;
      cmd_valid_o <= 1'b0;
      cmd_o       <= '0;
      cmd_data_o  <= '0;
    end else begin
      if (cmd_valid_o && cmd_ready_i) begin
        cmd_valid_o <= 1'b0;
      end

      if (wr_ack) begin
        case (reg_adr)
          A_CSR: begin
            e_bit  <= dat_i[7];
            ie_bit <= IRQ_EN & dat_i[6];
            if (!dat_i[7] && busy) begin
              busy        <= 1'b0;
              cmd_valid_o <= 1'b0;
              don         <= 1'b1;
              err         <= 1'b1;
            end
          end
          A_DPR: begin
            // keep the command payload stable while the request is outstanding
            if (!cmd_valid_o) begin
              cmd_data_o <= dat_i[7:0];
            end
          end
          A_CMDR: begin
            if (e_bit && !busy) begin
              don         <= 1'b0;
              nak         <= 1'b0;
              al          <= 1'b0;
              err         <= 1'b0;
              cmd_o       <= dat_i[2:0];
              busy        <= 1'b1;
              cmd_valid_o <= 1'b1;
            end else begin
              err <= 1'b1;
              don <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (rd_ack && reg_adr == A_CMDR) begin
        irq_q <= 1'b0;
      end

      if (done_i && busy) begin
        don     <= 1'b1;
        nak     <= done_sts_i[2];
        al      <= done_sts_i[1];
        err     <= done_sts_i[0];
        rx_data <= rx_data_i;
        busy    <= 1'b0;
        if (ie_bit) begin
          irq_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_adr)
      A_CSR:   rdata = {e_bit, ie_bit, bus_busy_i, 5'b00000};
      A_DPR:   rdata = rx_data;
      A_CMDR:  rdata = {don, nak, al, err, 1'b0, cmd_o};
      A_FSMR:  rdata = fsm_state_i;
      default: rdata = '0;
    endcase
    dat_o = ack_o ? DATA_WIDTH'(rdata) : '0;
  end

endmodule
